// File: rtl/eu_muldiv_arbiter.sv
// Round-robin arbiter that shares one fixed-latency MUL/DIV unit between EU way0 and way1.
// Optional performance counters are enabled with `define MULDIV_ARB_PERF_EN.
module eu_muldiv_arbiter #(
  parameter int PID_W   = 2,
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 33
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             way0_req_i,
  input  logic             way0_isDiv_i,
  input  logic [PID_W-1:0] way0_pID_i,
  input  logic [4:0]       way0_rdAddr_i,
  output logic             way0_grant_o,
  input  logic             way1_req_i,
  input  logic             way1_isDiv_i,
  input  logic [PID_W-1:0] way1_pID_i,
  input  logic [4:0]       way1_rdAddr_i,
  output logic             way1_grant_o,
  input  logic             jumpFlag_i,
  output logic             unit_start_o,
  output logic             unit_isDiv_o,
  output logic             unit_sel_o,
  output logic             unit_flush_o,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic             resp_way_o,
  output logic [PID_W-1:0] resp_pID_o,
  output logic [4:0]       resp_rdAddr_o,
  output logic [1:0]       dbg_state_o
`ifdef MULDIV_ARB_PERF_EN
  ,
  output logic [31:0]      perf_busy_o,
  output logic [31:0]      perf_conflict_o
`endif
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             rr_q;
  logic [PID_W-1:0] pid_q;
  logic [4:0]       rd_q;

  logic             any_req_c;
  logic             win_c;
  logic             isdiv_c;
  logic [PID_W-1:0] pid_c;
  logic [4:0]       rd_c;

  // With both ways requesting, rr_q names the favoured way; a lone request always wins.
  always_comb begin
    any_req_c = way0_req_i | way1_req_i;
    win_c     = (way0_req_i & way1_req_i) ? rr_q : way1_req_i;
    isdiv_c   = win_c ? way1_isDiv_i  : way0_isDiv_i;
    pid_c     = win_c ? way1_pID_i    : way0_pID_i;
    rd_c      = win_c ? way1_rdAddr_i : way0_rdAddr_i;
  end

  // Valid/ready: resp_* are held stable while resp_valid_o is high and resp_ready_i is low;
  // the response is consumed in the cycle where both are high.
  // Grant/start are registered and appear in the first BUSY cycle, so BUSY lasts exactly LAT cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      rr_q          <= 1'b0;
      pid_q         <= '0;
      rd_q          <= '0;
      way0_grant_o  <= 1'b0;
      way1_grant_o  <= 1'b0;
      unit_start_o  <= 1'b0;
      unit_isDiv_o  <= 1'b0;
      unit_sel_o    <= 1'b0;
      unit_flush_o  <= 1'b0;
      resp_valid_o  <= 1'b0;
      resp_way_o    <= 1'b0;
      resp_pID_o    <= '0;
      resp_rdAddr_o <= '0;
    end else begin
      way0_grant_o <= 1'b0;
      way1_grant_o <= 1'b0;
      unit_start_o <= 1'b0;
      unit_flush_o <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!jumpFlag_i && any_req_c) begin
            state_q      <= S_BUSY;
            way0_grant_o <= ~win_c;
            way1_grant_o <= win_c;
            unit_start_o <= 1'b1;
            unit_isDiv_o <= isdiv_c;
            unit_sel_o   <= win_c;
            pid_q        <= pid_c;
            rd_q         <= rd_c;
            cnt_q        <= isdiv_c ? DIV_CNT : MUL_CNT;
            rr_q         <= ~win_c;
          end
        end
        S_BUSY: begin
          if (jumpFlag_i) begin
            state_q      <= S_IDLE;
            unit_flush_o <= 1'b1;
            unit_isDiv_o <= 1'b0;
            unit_sel_o   <= 1'b0;
          end else if (cnt_q == '0) begin
            state_q       <= S_DONE;
            resp_valid_o  <= 1'b1;
            resp_way_o    <= unit_sel_o;
            resp_pID_o    <= pid_q;
            resp_rdAddr_o <= rd_q;
            unit_isDiv_o  <= 1'b0;
            unit_sel_o    <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_DONE: begin
          // A flush drops the response; the unit has already finished so no abort pulse.
          if (jumpFlag_i || resp_ready_i) begin
            state_q       <= S_IDLE;
            resp_valid_o  <= 1'b0;
            resp_way_o    <= 1'b0;
            resp_pID_o    <= '0;
            resp_rdAddr_o <= '0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dbg_state_o = state_q;

`ifdef MULDIV_ARB_PERF_EN
  logic [31:0] perf_busy_q;
  logic [31:0] perf_conflict_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_busy_q     <= '0;
      perf_conflict_q <= '0;
    end else begin
      if (state_q != S_IDLE && perf_busy_q != 32'hFFFF_FFFF)
        perf_busy_q <= perf_busy_q + 32'd1;
      if (state_q == S_IDLE && way0_req_i && way1_req_i && !jumpFlag_i &&
          perf_conflict_q != 32'hFFFF_FFFF)
        perf_conflict_q <= perf_conflict_q + 32'd1;
    end
  end

  assign perf_busy_o     = perf_busy_q;
  assign perf_conflict_o = perf_conflict_q;
`endif

endmodule
